// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: branch funct3 encodings and the 2-bit BHT
// saturating counter type with its update function.
package riscv_pkg;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t BHT_SNT = 2'b00;
  localparam bht_cnt_t BHT_WNT = 2'b01;
  localparam bht_cnt_t BHT_WT  = 2'b10;
  localparam bht_cnt_t BHT_ST  = 2'b11;

  function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
    bht_cnt_t nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != BHT_ST) nxt = cnt + 2'b01;
    end else begin
      if (cnt != BHT_SNT) nxt = cnt - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Bimodal table of 2-bit saturating counters: one combinational read port,
// one clocked read-modify-write training port. Reads never see a same-cycle write.
module bht_table
  import riscv_pkg::*;
#(
  parameter int       BHT_ENTRIES = 64,
  parameter bht_cnt_t CNT_INIT    = BHT_WNT,
  localparam int      IDX_W       = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output bht_cnt_t         rd_cnt_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  bht_cnt_t bht_q [BHT_ENTRIES];
  bht_cnt_t wr_cnt_d;

  assign rd_cnt_o = bht_q[rd_idx_i];
  assign wr_cnt_d = bht_next(bht_q[wr_idx_i], wr_taken_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= CNT_INIT;
      end
    end else if (wr_en_i) begin
      bht_q[wr_idx_i] <= wr_cnt_d;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution, bimodal prediction, mispredict/redirect and statistics.
// Resolve and redirect are combinational; BHT and stats update on the clock edge.
module branch_predict_unit
  import riscv_pkg::*;
#(
  parameter int       XLEN        = 32,
  parameter int       BHT_ENTRIES = 64,
  parameter bht_cnt_t CNT_INIT    = 2'b01,
  parameter int       STAT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_pc,
  output logic              pred_taken,
  input  logic              ex_valid,
  input  logic              ex_stall,
  input  logic              ex_branch,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_rs1,
  input  logic [XLEN-1:0]   ex_rs2,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_target,
  input  logic              ex_pred_taken,
  output logic              ex_taken,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic              funct3_legal;
  logic              cond_true;
  logic              resolve;
  logic              train;
  logic              op_eq;
  logic              op_lt_s;
  logic              op_lt_u;
  bht_cnt_t          if_cnt;
  logic [STAT_W-1:0] stat_br_q, stat_br_d;
  logic [STAT_W-1:0] stat_mp_q, stat_mp_d;
  logic              unused_if_pc_bits;

  // Only the word-index bits of the fetch PC address the table.
  assign unused_if_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  bht_table #(
    .BHT_ENTRIES(BHT_ENTRIES),
    .CNT_INIT   (CNT_INIT)
  ) u_bht (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx_i  (if_pc[IDX_W+1:2]),
    .rd_cnt_o  (if_cnt),
    .wr_en_i   (train),
    .wr_idx_i  (ex_pc[IDX_W+1:2]),
    .wr_taken_i(ex_taken)
  );

  assign pred_taken = if_cnt[1];

  assign op_eq   = (ex_rs1 == ex_rs2);
  assign op_lt_s = ($signed(ex_rs1) < $signed(ex_rs2));
  assign op_lt_u = (ex_rs1 < ex_rs2);

  always_comb begin
    funct3_legal = 1'b1;
    cond_true    = 1'b0;
    unique case (ex_funct3)
      FUNCT3_BEQ:  cond_true = op_eq;
      FUNCT3_BNE:  cond_true = !op_eq;
      FUNCT3_BLT:  cond_true = op_lt_s;
      FUNCT3_BGE:  cond_true = !op_lt_s;
      FUNCT3_BLTU: cond_true = op_lt_u;
      FUNCT3_BGEU: cond_true = !op_lt_u;
      default:     funct3_legal = 1'b0;
    endcase
  end

  assign resolve    = ex_valid & ex_branch & funct3_legal;
  assign ex_taken   = resolve & cond_true;
  assign mispredict = resolve & (ex_taken != ex_pred_taken);
  // A stalled branch keeps flagging its mispredict but trains and counts only once it leaves the stall.
  assign train      = resolve & !ex_stall;

  always_comb begin
    redirect_pc = '0;
    if (mispredict) begin
      redirect_pc = ex_taken ? ex_target : (ex_pc + XLEN'(4));
    end
  end

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (train) begin
      if (stat_br_q != '1) stat_br_d = stat_br_q + STAT_W'(1);
      if (mispredict && (stat_mp_q != '1)) stat_mp_d = stat_mp_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed vectors with hand-computed expectations; a negedge monitor pops the
// scoreboard and compares a default unit and a STAT_W=4 unit driven in parallel.
module tb_branch_predict_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        ex_valid, ex_stall, ex_branch, ex_pred_taken;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_rs1, ex_rs2, ex_pc, ex_target;

  logic        pred_taken, ex_taken, mispredict;
  logic [31:0] redirect_pc, stat_branches, stat_mispredicts;

  logic        s_pred_taken, s_ex_taken, s_mispredict;
  logic [31:0] s_redirect_pc;
  logic [3:0]  s_stat_branches, s_stat_mispredicts;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        pred;
    logic        taken;
    logic        mis;
    logic [31:0] redir;
    logic [31:0] br;
    logic [31:0] mp;
    logic [3:0]  sbr;
    logic [3:0]  smp;
  } exp_t;

  exp_t sb_q [$];

  branch_predict_unit u_dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_branch(ex_branch),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  branch_predict_unit #(.STAT_W(4)) u_dut_s4 (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(s_pred_taken),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_branch(ex_branch),
    .ex_funct3(ex_funct3), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_pc(ex_pc),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_taken(s_ex_taken),
    .mispredict(s_mispredict), .redirect_pc(s_redirect_pc),
    .stat_branches(s_stat_branches), .stat_mispredicts(s_stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("pred_taken", {31'd0, pred_taken}, {31'd0, e.pred});
      chk("ex_taken", {31'd0, ex_taken}, {31'd0, e.taken});
      chk("mispredict", {31'd0, mispredict}, {31'd0, e.mis});
      chk("redirect_pc", redirect_pc, e.redir);
      chk("stat_branches", stat_branches, e.br);
      chk("stat_mispredicts", stat_mispredicts, e.mp);
      chk("s4_stat_branches", {28'd0, s_stat_branches}, {28'd0, e.sbr});
      chk("s4_stat_mispredicts", {28'd0, s_stat_mispredicts}, {28'd0, e.smp});
    end
  end

  task automatic push(input logic p, input logic t, input logic m, input logic [31:0] r,
                      input logic [31:0] b, input logic [31:0] mp,
                      input logic [3:0] sb, input logic [3:0] smp);
    exp_t e;
    e.pred = p; e.taken = t; e.mis = m; e.redir = r;
    e.br = b; e.mp = mp; e.sbr = sb; e.smp = smp;
    sb_q.push_back(e);
  endtask

  task automatic vec(input logic v, input logic br, input logic [2:0] f3,
                     input logic [31:0] rs1, input logic [31:0] rs2,
                     input logic [31:0] pc, input logic [31:0] tgt,
                     input logic ept, input logic stall, input logic [31:0] ifpc,
                     input logic e_pred, input logic e_taken, input logic e_mis,
                     input logic [31:0] e_redir, input logic [31:0] e_br,
                     input logic [31:0] e_mp, input logic [3:0] e_sbr,
                     input logic [3:0] e_smp);
    ex_valid = v; ex_branch = br; ex_funct3 = f3; ex_rs1 = rs1; ex_rs2 = rs2;
    ex_pc = pc; ex_target = tgt; ex_pred_taken = ept; ex_stall = stall; if_pc = ifpc;
    push(e_pred, e_taken, e_mis, e_redir, e_br, e_mp, e_sbr, e_smp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] ifpc, input logic e_pred,
                      input logic [31:0] e_br, input logic [31:0] e_mp,
                      input logic [3:0] e_sbr, input logic [3:0] e_smp);
    vec(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, ifpc,
        e_pred, 1'b0, 1'b0, 32'd0, e_br, e_mp, e_sbr, e_smp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if_pc = '0; ex_valid = 0; ex_stall = 0; ex_branch = 0; ex_funct3 = '0;
    ex_rs1 = '0; ex_rs2 = '0; ex_pc = '0; ex_target = '0; ex_pred_taken = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset state
    idle(32'h100, 0, 0, 0, 0, 0);
    // taken BEQ predicted NT at 0x100
    vec(1, 1, 3'b000, 5, 5, 32'h100, 32'h200, 0, 0, 32'h100, 0, 1, 1, 32'h200, 0, 0, 0, 0);
    idle(32'h100, 1, 1, 1, 1, 1);
    // signed vs unsigned less-than on 0xFFFFFFFF vs 1
    vec(1, 1, 3'b100, 32'hFFFF_FFFF, 1, 32'h104, 32'h300, 1, 0, 32'h104, 0, 1, 0, 0, 1, 1, 1, 1);
    vec(1, 1, 3'b110, 32'hFFFF_FFFF, 1, 32'h108, 32'h400, 1, 0, 32'h108, 0, 0, 1, 32'h10C, 2, 1, 2, 1);
    // four taken BNE at index 3, then two not-taken
    vec(1, 1, 3'b001, 1, 2, 32'h10C, 32'h500, 1, 0, 32'h10C, 0, 1, 0, 0, 3, 2, 3, 2);
    vec(1, 1, 3'b001, 1, 2, 32'h10C, 32'h500, 1, 0, 32'h10C, 1, 1, 0, 0, 4, 2, 4, 2);
    vec(1, 1, 3'b001, 1, 2, 32'h10C, 32'h500, 1, 0, 32'h10C, 1, 1, 0, 0, 5, 2, 5, 2);
    vec(1, 1, 3'b001, 1, 2, 32'h10C, 32'h500, 1, 0, 32'h10C, 1, 1, 0, 0, 6, 2, 6, 2);
    idle(32'h10C, 1, 7, 2, 7, 2);
    vec(1, 1, 3'b101, 1, 2, 32'h10C, 32'h500, 1, 0, 32'h10C, 1, 0, 1, 32'h110, 7, 2, 7, 2);
    idle(32'h10C, 1, 8, 3, 8, 3);
    vec(1, 1, 3'b111, 1, 2, 32'h10C, 32'h500, 0, 0, 32'h10C, 1, 0, 0, 0, 8, 3, 8, 3);
    idle(32'h10C, 0, 9, 3, 9, 3);
    // illegal funct3 and invalid EX must not resolve, train or count
    vec(1, 1, 3'b010, 5, 5, 32'h100, 32'h200, 0, 0, 32'h100, 1, 0, 0, 0, 9, 3, 9, 3);
    vec(1, 1, 3'b011, 5, 5, 32'h100, 32'h200, 0, 0, 32'h100, 1, 0, 0, 0, 9, 3, 9, 3);
    vec(0, 1, 3'b000, 5, 5, 32'h100, 32'h200, 0, 0, 32'h100, 1, 0, 0, 0, 9, 3, 9, 3);
    idle(32'h100, 1, 9, 3, 9, 3);
    // mispredicting branch held three cycles in stall
    for (int i = 0; i < 3; i++) begin
      vec(1, 1, 3'b000, 1, 2, 32'h110, 32'h700, 1, 1, 32'h110, 0, 0, 1, 32'h114, 9, 3, 9, 3);
    end
    vec(1, 1, 3'b000, 1, 2, 32'h110, 32'h700, 1, 0, 32'h110, 0, 0, 1, 32'h114, 9, 3, 9, 3);
    idle(32'h110, 0, 10, 4, 10, 4);
    // ten more correctly predicted taken branches: STAT_W=4 unit saturates at 15
    for (int i = 0; i < 10; i++) begin
      vec(1, 1, 3'b000, 0, 0, 32'h114, 32'h600, 1, 0, 32'h100, 1, 1, 0, 0,
          32'(10 + i), 4, 4'((10 + i > 15) ? 15 : 10 + i), 4);
    end
    idle(32'h100, 1, 20, 4, 15, 4);
    // asynchronous reset with no clock edge before the check
    rst_n = 1'b0;
    idle(32'h100, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    idle(32'h10C, 0, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
